spi_master: RTL

- Memory-mapped SPI master (mode 0, MSB first, 8-bit frames) on the common memory bus, downstream of the top-level address decoder.
- Decoded at 32'h0004_0000–32'h0004_000F; the top-level decoder drives its sel_in.
- Read data is zero when not selected, so it ORs into the shared read-value bus like the other peripherals.
- Drives an external SPI device: SCK, MOSI, MISO and a software-controlled chip select.

---
 rtl/spi_master.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: memory-mapped SPI master (mode 0, MSB first, 8-bit frames) with
// software chip select and a programmable SCK half-period of DIV+1 clk cycles.
module spi_master #(
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        sck_out,
    output logic        mosi_out,
    input  logic        miso_in,
    output logic        csn_out
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;
    logic [15:0] div_reg, div_cur, div_cur_nxt, cnt, cnt_nxt;
    logic [3:0]  edges, edges_nxt;
    logic [7:0]  shreg, shreg_nxt, rx_byte, rx_byte_nxt;
    logic        rx_bit, rx_bit_nxt, rx_valid, rx_valid_nxt, sck_nxt, mosi_nxt;
    logic        cs_assert, busy, data_wr, data_rd;
    logic [1:0]  miso_sync, reg_sel;
    logic        unused_bits;

    assign unused_bits = ^{address_in[31:4], address_in[1:0], write_value_in[31:16]};
    assign reg_sel = address_in[3:2];
    assign busy = (state == SHIFT);
    assign data_wr = sel_in && reg_sel == 2'd0 && write_mask_in[0];
    assign data_rd = sel_in && read_in && reg_sel == 2'd0;
    // A DATA write during a transfer stalls the bus until the shifter is idle.
    assign ready_out = sel_in && !(data_wr && busy);
    assign csn_out = ~cs_assert;
    assign read_value_out = !sel_in ? 32'd0 :
                            reg_sel == 2'd0 ? {24'd0, rx_byte} :
                            reg_sel == 2'd1 ? {30'd0, rx_valid, busy} :
                            reg_sel == 2'd2 ? {16'd0, div_reg} : {31'd0, cs_assert};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miso_sync <= 2'b00;
            div_reg   <= DEFAULT_DIV;
            cs_assert <= 1'b0;
        end else begin
            miso_sync <= {miso_sync[0], miso_in};
            if (sel_in && reg_sel == 2'd2 && write_mask_in[0]) div_reg[7:0] <= write_value_in[7:0];
            if (sel_in && reg_sel == 2'd2 && write_mask_in[1]) div_reg[15:8] <= write_value_in[15:8];
            if (sel_in && reg_sel == 2'd3 && write_mask_in[0]) cs_assert <= write_value_in[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            div_cur  <= 16'd0;
            cnt      <= 16'd0;
            edges    <= 4'd0;
            shreg    <= 8'd0;
            rx_bit   <= 1'b0;
            rx_byte  <= 8'd0;
            rx_valid <= 1'b0;
            sck_out  <= 1'b0;
            mosi_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cur  <= div_cur_nxt;
            cnt      <= cnt_nxt;
            edges    <= edges_nxt;
            shreg    <= shreg_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_byte  <= rx_byte_nxt;
            rx_valid <= rx_valid_nxt;
            sck_out  <= sck_nxt;
            mosi_out <= mosi_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_cur_nxt  = div_cur;
        cnt_nxt      = cnt;
        edges_nxt    = edges;
        shreg_nxt    = shreg;
        rx_bit_nxt   = rx_bit;
        rx_byte_nxt  = rx_byte;
        rx_valid_nxt = rx_valid && !data_rd;
        sck_nxt      = sck_out;
        mosi_nxt     = mosi_out;
        case (state)
            IDLE: if (data_wr) begin
                state_nxt   = SHIFT;
                div_cur_nxt = div_reg;
                cnt_nxt     = 16'd0;
                edges_nxt   = 4'd0;
                shreg_nxt   = write_value_in[7:0];
                mosi_nxt    = write_value_in[7];
            end
            SHIFT: if (cnt != div_cur) begin
                cnt_nxt = cnt + 16'd1;
            end else begin
                cnt_nxt   = 16'd0;
                sck_nxt   = ~sck_out;
                edges_nxt = edges + 4'd1;
                // The sampled bit is held aside so the LSB still being sent is not clobbered.
                if (!sck_out) rx_bit_nxt = miso_sync[1];
                else begin
                    shreg_nxt = {shreg[6:0], rx_bit};
                    mosi_nxt  = shreg[6];
                end
                if (edges == 4'd15) begin
                    state_nxt    = IDLE;
                    rx_byte_nxt  = {shreg[6:0], rx_bit};
                    rx_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
